// File: rtl/riscv_pkg.sv
// Shared RV32 core constants, Memory-stage FSM state type and result-source encoding.
package riscv_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } mem_state_t;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  // A slot touches data memory when it is real and is either a load or a store.
  function automatic logic is_mem_op(input logic valid, input logic result_src,
                                     input logic mem_write);
    return valid & ((result_src == RES_MEM) | mem_write);
  endfunction

endpackage

// File: rtl/mw_pipe_reg.sv
// Generic pipeline register with load enable and bubble insertion; bits set in BubbleMask
// are cleared on a bubble while all other bits hold.
module mw_pipe_reg #(
  parameter int unsigned     Width      = 1,
  parameter logic [Width-1:0] BubbleMask = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_bubble,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q <= r_q & ~BubbleMask;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/memory_stage.sv
// RV32 Memory stage: data-memory handshake, pipeline stall and M/W register.
// Optional macro MEM_MISALIGN_CHECK_EN drops misaligned accesses and flags them on misalign_w.
module memory_stage #(
  parameter int unsigned DATA_W     = riscv_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic                  RegWriteM,
  input  logic                  ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [DATA_W-1:0]     ALUResultM,
  input  logic [DATA_W-1:0]     WriteDataM,
  input  logic [DATA_W-1:0]     PCPlus4M,
  input  logic [REG_ADDR_W-1:0] RDM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  stall_m,
  output logic                  valid_w,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [DATA_W-1:0]     ALUResultW,
  output logic [DATA_W-1:0]     ReadDataW,
  output logic [DATA_W-1:0]     PCPlus4W,
  output logic [REG_ADDR_W-1:0] RDW
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_w
`endif
);

  import riscv_pkg::*;

  localparam int unsigned MwW = 3 + 3 * DATA_W + REG_ADDR_W;
  // valid and RegWrite sit in the top two bits; bubbles clear only those.
  localparam logic [MwW-1:0] MwBubbleMask = {2'b11, {(MwW - 2){1'b0}}};

  mem_state_t r_state, w_state_next;

  logic              w_mem_op;
  logic              w_misalign;
  logic              w_access;
  logic              w_load;
  logic              w_req;
  logic              w_stall;
  logic [DATA_W-1:0] w_read_data;
  logic [MwW-1:0]    w_mw_d;
  logic [MwW-1:0]    w_mw_q;

  assign w_mem_op = is_mem_op(valid_m, ResultSrcM, MemWriteM);

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = w_mem_op & (ALUResultM[1:0] != 2'b00) & (r_state == IDLE);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access = w_mem_op & ~w_misalign;
  assign w_load   = valid_m & (ResultSrcM == RES_MEM);

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        w_req   = w_access;
        w_stall = w_access & ~dmem_ready;
        if (w_stall) w_state_next = WAIT;
      end
      WAIT: begin
        w_req   = 1'b1;
        w_stall = ~dmem_ready;
        if (dmem_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Reset abandons any in-flight request immediately.
    if (rst) begin
      w_req   = 1'b0;
      w_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = WriteDataM;
  assign stall_m    = w_stall;

  assign w_read_data = w_load ? dmem_rdata : '0;
  assign w_mw_d      = {valid_m, RegWriteM & valid_m, ResultSrcM, ALUResultM, w_read_data,
                        PCPlus4M, RDM};

  mw_pipe_reg #(
    .Width      (MwW),
    .BubbleMask (MwBubbleMask)
  ) u_mw_reg (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (~w_stall),
    .i_bubble (w_stall | w_misalign),
    .i_d      (w_mw_d),
    .o_q      (w_mw_q)
  );

  assign {valid_w, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RDW} = w_mw_q;

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
    end
  end

  assign misalign_w = r_misalign;
`endif

endmodule
